// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register, one-entry skid buffer and branch redirect.
// Optional performance counters are built when IF_FETCH_PERF_EN is defined.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic [31:0] new_pc_value,
  output logic        if_valid
`ifdef IF_FETCH_PERF_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] flush_count
`endif
);

  typedef enum logic [1:0] {FETCH, HOLD, DISCARD} state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] addr_q;
  logic        req_q;
  logic [31:0] skid_instr;
  logic [31:0] skid_pc4;
  logic [31:0] addr_inc;

  assign addr_inc  = addr_q + 32'd4;
  assign imem_req  = req_q;
  assign imem_addr = addr_q;

  // req_q distinguishes "FETCH with a request in flight" from "FETCH, not yet issued" after reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= FETCH;
      pc           <= RESET_PC;
      addr_q       <= RESET_PC;
      req_q        <= 1'b0;
      skid_instr   <= 32'd0;
      skid_pc4     <= 32'd0;
      instruction  <= NOP_INSTR;
      new_pc_value <= 32'd0;
      if_valid     <= 1'b0;
    end else if (branch_taken) begin
      instruction <= NOP_INSTR;
      if_valid    <= 1'b0;
      pc          <= branch_target;
      skid_instr  <= 32'd0;
      skid_pc4    <= 32'd0;
      // An unfinished request cannot be aborted, so it is drained in DISCARD first.
      if (req_q && !imem_ready) begin
        state <= DISCARD;
      end else begin
        state  <= FETCH;
        req_q  <= 1'b1;
        addr_q <= branch_target;
      end
    end else begin
      case (state)
        FETCH: begin
          if (!req_q) begin
            req_q  <= 1'b1;
            addr_q <= pc;
            if (!stall) begin
              instruction <= NOP_INSTR;
              if_valid    <= 1'b0;
            end
          end else if (imem_ready) begin
            if (!stall) begin
              instruction  <= imem_rdata;
              new_pc_value <= addr_inc;
              if_valid     <= 1'b1;
              pc           <= addr_inc;
              addr_q       <= addr_inc;
            end else begin
              skid_instr <= imem_rdata;
              skid_pc4   <= addr_inc;
              req_q      <= 1'b0;
              state      <= HOLD;
            end
          end else if (!stall) begin
            instruction <= NOP_INSTR;
            if_valid    <= 1'b0;
          end
        end
        HOLD: begin
          if (!stall) begin
            instruction  <= skid_instr;
            new_pc_value <= skid_pc4;
            if_valid     <= 1'b1;
            pc           <= skid_pc4;
            addr_q       <= skid_pc4;
            req_q        <= 1'b1;
            state        <= FETCH;
          end
        end
        DISCARD: begin
          instruction <= NOP_INSTR;
          if_valid    <= 1'b0;
          if (imem_ready) begin
            addr_q <= pc;
            req_q  <= 1'b1;
            state  <= FETCH;
          end
        end
        default: begin
          state <= FETCH;
        end
      endcase
    end
  end

`ifdef IF_FETCH_PERF_EN
  logic load_valid;

  assign load_valid = !branch_taken && !stall &&
                      ((state == FETCH && req_q && imem_ready) || state == HOLD);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_count <= 32'd0;
      flush_count <= 32'd0;
    end else begin
      if (load_valid) begin
        fetch_count <= fetch_count + 32'd1;
      end
      if (branch_taken) begin
        flush_count <= flush_count + 32'd1;
      end
    end
  end
`endif

endmodule
